// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: 2-bit saturating counter table trained at EX resolution.
// Optional gshare indexing (global history XOR PC) is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int PC_WIDTH   = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_is_branch,
   input  logic [PC_WIDTH-1:0]   id_pc,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_ghr,
   input  logic                  ex_is_branch,
   input  logic [PC_WIDTH-1:0]   ex_pc,
   input  logic [INDEX_BITS-1:0] ex_ghr,
   input  logic                  ex_br_taken,
   input  logic                  ex_br_suc,
   input  logic                  ex_br_mispred,
   output logic [CNT_WIDTH-1:0]  stat_branches,
   output logic [CNT_WIDTH-1:0]  stat_mispreds,
   output logic                  err_sticky
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            cnt_tbl [ENTRIES];
   logic [INDEX_BITS-1:0] lu_idx;
   logic [INDEX_BITS-1:0] up_idx;
   logic                  upd_vld;
   logic                  proto_err;
   logic                  actual;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
      if (up)
         return (cnt == 2'b11) ? cnt : cnt + 2'd1;
      else
         return (cnt == 2'b00) ? cnt : cnt - 2'd1;
   endfunction

   // Exactly one of suc/mispred must accompany a resolved branch.
   assign upd_vld   = ex_is_branch & (ex_br_suc ^ ex_br_mispred);
   assign proto_err = ex_is_branch & ~(ex_br_suc ^ ex_br_mispred);
   assign actual    = ex_br_taken ^ ex_br_mispred;

`ifdef BP_GSHARE_EN
   logic [INDEX_BITS-1:0] ghr;
   logic                  unused_bits;

   assign lu_idx      = id_pc[INDEX_BITS+1:2] ^ ghr;
   assign up_idx      = ex_pc[INDEX_BITS+1:2] ^ ex_ghr;
   assign pred_ghr    = ghr;
   assign unused_bits = ^{id_pc[PC_WIDTH-1:INDEX_BITS+2], id_pc[1:0],
                          ex_pc[PC_WIDTH-1:INDEX_BITS+2], ex_pc[1:0]};

   // History is non-speculative: it only moves when EX resolves a branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ghr <= '0;
      else if (upd_vld)
         ghr <= {ghr[INDEX_BITS-2:0], actual};
   end
`else
   logic unused_bits;

   assign lu_idx      = id_pc[INDEX_BITS+1:2];
   assign up_idx      = ex_pc[INDEX_BITS+1:2];
   assign pred_ghr    = '0;
   assign unused_bits = ^{id_pc[PC_WIDTH-1:INDEX_BITS+2], id_pc[1:0],
                          ex_pc[PC_WIDTH-1:INDEX_BITS+2], ex_pc[1:0], ex_ghr};
`endif

   // Lookup reads the registered table directly, so a same-cycle update is not bypassed.
   assign pred_taken = id_valid & id_is_branch & cnt_tbl[lu_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++)
            cnt_tbl[i] <= 2'b01;
      end else if (upd_vld) begin
         cnt_tbl[up_idx] <= sat_update(cnt_tbl[up_idx], actual);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches <= '0;
         stat_mispreds <= '0;
         err_sticky    <= 1'b0;
      end else begin
         if (upd_vld) begin
            stat_branches <= stat_branches + 1'b1;
            if (ex_br_mispred)
               stat_mispreds <= stat_mispreds + 1'b1;
         end
         if (proto_err)
            err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal by default, gshare with BP_GSHARE_EN).
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic        id_is_branch;
   logic [31:0] id_pc;
   logic        pred_taken;
   logic [5:0]  pred_ghr;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic [5:0]  ex_ghr;
   logic        ex_br_taken;
   logic        ex_br_suc;
   logic        ex_br_mispred;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispreds;
   logic        err_sticky;

   int n_cmp = 0;
   int n_err = 0;

   branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc),
      .pred_taken(pred_taken), .pred_ghr(pred_ghr),
      .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_ghr(ex_ghr),
      .ex_br_taken(ex_br_taken), .ex_br_suc(ex_br_suc), .ex_br_mispred(ex_br_mispred),
      .stat_branches(stat_branches), .stat_mispreds(stat_mispreds), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
      id_valid     = 1'b1;
      id_is_branch = 1'b1;
      id_pc        = pc;
      #1;
      chk(tag, {31'd0, pred_taken}, {31'd0, exp});
   endtask

   task automatic upd(input logic [31:0] pc, input logic [5:0] gh, input logic tk,
                      input logic suc, input logic mis);
      ex_is_branch  = 1'b1;
      ex_pc         = pc;
      ex_ghr        = gh;
      ex_br_taken   = tk;
      ex_br_suc     = suc;
      ex_br_mispred = mis;
      @(posedge clk);
      #1;
      ex_is_branch  = 1'b0;
      ex_br_suc     = 1'b0;
      ex_br_mispred = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      id_valid = 1'b0; id_is_branch = 1'b0; id_pc = '0;
      ex_is_branch = 1'b0; ex_pc = '0; ex_ghr = '0;
      ex_br_taken = 1'b0; ex_br_suc = 1'b0; ex_br_mispred = 1'b0;
      do_reset();

      lookup("rst_pred_0x100", 32'h100, 1'b0);
      chk("rst_branches", stat_branches, 32'd0);
      chk("rst_mispreds", stat_mispreds, 32'd0);
      chk("rst_err", {31'd0, err_sticky}, 32'd0);
      chk("rst_ghr", {26'd0, pred_ghr}, 32'd0);

`ifdef BP_GSHARE_EN
      // taken update at pc 0 with ghr 0: entry 0 -> 10, GHR -> 000001
      upd(32'h0, 6'd0, 1'b1, 1'b1, 1'b0);
      chk("gs_ghr", {26'd0, pred_ghr}, 32'h01);
      lookup("gs_pc0_idx1", 32'h0, 1'b0);
      lookup("gs_pc4_idx0", 32'h4, 1'b1);
      chk("gs_branches", stat_branches, 32'd1);
      // not-taken update shifts a 0 in: GHR -> 000010
      upd(32'h8, 6'h01, 1'b0, 1'b1, 1'b0);
      chk("gs_ghr2", {26'd0, pred_ghr}, 32'h02);
      lookup("gs_pc8_idx0", 32'h8, 1'b1);
`else
      // 0x100 (idx 0): two mispredicted not-taken = actual taken, 01->10->11
      upd(32'h100, 6'd0, 1'b0, 1'b0, 1'b1);
      lookup("bm_100_after1", 32'h100, 1'b1);
      upd(32'h100, 6'd0, 1'b0, 1'b0, 1'b1);
      lookup("bm_100_after2", 32'h100, 1'b1);
      chk("bm_mispreds2", stat_mispreds, 32'd2);
      chk("bm_branches2", stat_branches, 32'd2);

      // 0x104: four taken saturate at 11, then 10, then 01
      for (int i = 0; i < 4; i++) upd(32'h104, 6'd0, 1'b1, 1'b1, 1'b0);
      upd(32'h104, 6'd0, 1'b1, 1'b0, 1'b1);
      lookup("bm_104_sat_dec", 32'h104, 1'b1);
      upd(32'h104, 6'd0, 1'b0, 1'b1, 1'b0);
      lookup("bm_104_dec2", 32'h104, 1'b0);
      chk("bm_branches8", stat_branches, 32'd8);
      chk("bm_mispreds3", stat_mispreds, 32'd3);

      // Same-cycle lookup and update of 0x108: no bypass
      @(negedge clk);
      id_valid = 1'b1; id_is_branch = 1'b1; id_pc = 32'h108;
      ex_is_branch = 1'b1; ex_pc = 32'h108; ex_br_taken = 1'b1;
      ex_br_suc = 1'b1; ex_br_mispred = 1'b0;
      #1;
      chk("bm_108_same_cyc", {31'd0, pred_taken}, 32'd0);
      @(posedge clk);
      #1;
      ex_is_branch = 1'b0; ex_br_suc = 1'b0;
      #1;
      chk("bm_108_next_cyc", {31'd0, pred_taken}, 32'd1);

      // Lookup gating and index aliasing
      id_is_branch = 1'b0; id_pc = 32'h100; #1;
      chk("bm_nonbranch", {31'd0, pred_taken}, 32'd0);
      id_is_branch = 1'b1; id_valid = 1'b0; #1;
      chk("bm_invalid", {31'd0, pred_taken}, 32'd0);
      lookup("bm_pc_lowbits", 32'h103, 1'b1);
      lookup("bm_pc_alias", 32'h200, 1'b1);
      chk("bm_ghr_tied", {26'd0, pred_ghr}, 32'd0);
`endif

      // Protocol violations at a fresh index: no training, no stats, sticky error
      begin
         logic [31:0] b0, m0;
         b0 = stat_branches;
         m0 = stat_mispreds;
         chk("pre_err", {31'd0, err_sticky}, 32'd0);
         upd(32'h10C, pred_ghr, 1'b0, 1'b1, 1'b1);
         chk("err_both_set", {31'd0, err_sticky}, 32'd1);
         upd(32'h10C, pred_ghr, 1'b0, 1'b0, 1'b0);
         chk("err_sticks", {31'd0, err_sticky}, 32'd1);
         chk("err_branches", stat_branches, b0);
         chk("err_mispreds", stat_mispreds, m0);
         // flags without ex_is_branch are ignored
         ex_pc = 32'h10C; ex_br_taken = 1'b0; ex_br_mispred = 1'b1;
         @(posedge clk); #1;
         ex_br_mispred = 1'b0;
         chk("ignored_branches", stat_branches, b0);
`ifndef BP_GSHARE_EN
         lookup("err_10c_untrained", 32'h10C, 1'b0);
`endif
      end

      // Asynchronous reset mid-cycle clears everything immediately
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_branches", stat_branches, 32'd0);
      chk("arst_mispreds", stat_mispreds, 32'd0);
      chk("arst_err", {31'd0, err_sticky}, 32'd0);
      chk("arst_ghr", {26'd0, pred_ghr}, 32'd0);
      id_valid = 1'b1; id_is_branch = 1'b1; id_pc = 32'h104; #1;
      chk("arst_pred", {31'd0, pred_taken}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the 5-stage RISC-V core.
- Sits upstream of the EX-stage control. At decode it supplies the predicted direction, which is pipelined to EX as `br_taken`.
- EX resolves the branch and reports the outcome back through `br_suc` / `br_mispred`; this block then trains a table of 2-bit saturating counters.
- Also keeps branch and mispredict statistics for CSR readout.

Parameters:
- INDEX_BITS, 6, log2 of counter-table entries (64 entries).
- PC_WIDTH, 32, width of PC inputs.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a valid instruction.
- id_is_branch  in  1  decode instruction is a conditional branch (opcode BRANCH).
- id_pc  in  PC_WIDTH  PC of the decode instruction.
- pred_taken  out  1  predicted direction for the decode instruction.
- pred_ghr  out  INDEX_BITS  history snapshot used for this lookup; the pipeline carries it to EX.
- ex_is_branch  in  1  EX instruction is a valid, unflushed conditional branch.
- ex_pc  in  PC_WIDTH  PC of the EX branch.
- ex_ghr  in  INDEX_BITS  pred_ghr value carried with the EX branch.
- ex_br_taken  in  1  prediction that was made for the EX branch.
- ex_br_suc  in  1  EX reports the prediction correct.
- ex_br_mispred  in  1  EX reports the prediction wrong.
- stat_branches  out  CNT_WIDTH  resolved-branch count.
- stat_mispreds  out  CNT_WIDTH  mispredict count.
- err_sticky  out  1  protocol-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - every counter = 2'b01 (weakly not-taken);
  - GHR = 0; stat_branches = 0; stat_mispreds = 0; err_sticky = 0.
  - Consequently pred_taken = 0 and pred_ghr = 0.
  - Reset asserted mid-operation discards all state immediately; no update completes.
- Lookup index: lu_idx = id_pc[INDEX_BITS+1:2]; PC bits [1:0] are ignored.
- Lookup is combinational, zero latency:
  - pred_taken = id_valid & id_is_branch & table[lu_idx][1];
  - pred_taken = 0 for non-branches.
- pred_ghr equals the current GHR whenever the feature is on, else 0.
- Update index: up_idx = ex_pc[INDEX_BITS+1:2].
- Update occurs on a clock edge when ex_is_branch = 1 and exactly one of ex_br_suc / ex_br_mispred is 1.
- Actual outcome: actual = ex_br_taken XOR ex_br_mispred.
- Counter rules:
  - actual = 1: counter increments, saturating at 2'b11.
  - actual = 0: counter decrements, saturating at 2'b00.
- Statistics:
  - stat_branches increments by 1 per valid update;
  - stat_mispreds increments by 1 when ex_br_mispred = 1;
  - both wrap modulo 2^CNT_WIDTH.
- Protocol error: ex_is_branch = 1 with both flags 1, or with both flags 0, is a violation. Response:
  - no table, GHR or stats update;
  - err_sticky set to 1, cleared only by reset.
- ex_br_suc / ex_br_mispred asserted while ex_is_branch = 0 is ignored (non-branch EX instructions).
- Simultaneous lookup and update to the same index: lookup returns the pre-update value. The write becomes visible the cycle after the edge; there is no bypass.
- Back-to-back updates to the same index on consecutive cycles each apply, cumulatively.
- Decode stalls and flushes need no handling here: lookup has no side effects and only EX-resolved branches train.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined (gshare indexing):
  - lu_idx = id_pc[INDEX_BITS+1:2] XOR GHR;
  - up_idx = ex_pc[INDEX_BITS+1:2] XOR ex_ghr.
  - On each valid update the GHR shifts left by one, with actual entering bit 0.
  - The GHR is non-speculative: updated only at EX resolution.
  - pred_ghr = GHR.
- Undefined (bimodal):
  - the GHR register is removed; pred_ghr is tied to 0;
  - ex_ghr is ignored;
  - indexing is PC-only.

Test Plan:
- Reset, then id_valid = 1, id_is_branch = 1, id_pc = 0x100 -> pred_taken = 0; stat_branches = 0; err_sticky = 0.
- Two resolved updates at ex_pc = 0x100 with ex_br_taken = 0, ex_br_mispred = 1 -> counter goes 01→10→11; lookup of 0x100 then gives pred_taken = 1; stat_mispreds = 2.
- Four actual-taken updates at 0x104, then one not-taken -> counter saturates at 11, then reads 10; pred_taken stays 1.
- Same cycle: lookup 0x108 and update 0x108 (counter 01→10) -> pred_taken = 0 that cycle, 1 the next cycle.
- ex_is_branch = 1 with ex_br_suc = ex_br_mispred = 1 -> err_sticky = 1; table and stats unchanged.
- BP_GSHARE_EN defined: after a taken update, GHR = 0x01. Lookup at id_pc = 0x0 uses index 1 and pred_ghr = 0x01. Deasserting rst_n mid-sequence returns GHR and all outputs to 0 immediately.
